dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Multi-cycle data-memory responder serving load/store requests from the pipeline's memory stage over a valid/ready request channel and a valid/ready response channel. It owns word-organised storage and performs byte/half/word accesses with sign or zero extension and alignment checking. It is the responder end of the memory stage's data-memory access interface. It replaces the single-cycle memory model when modelling realistic memory latency and stalls.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, data width; fixed at 32, byte lanes = 4
DEPTH_WORDS, 1024, number of 32-bit words stored; word index = req_addr[ADDR_W-1:2]
LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..15

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0])
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
rsp_valid  out  1  response present
rsp_rdata  out  DATA_W  load result; 0 for stores and errors
rsp_err  out  1  access error (misaligned, illegal size, out of range)
rsp_ready  in  1  consumer accepts response

Behaviour:
- Reset (async, any cycle): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter 0. Storage contents are not cleared. A request accepted but not yet committed is dropped with no write. A response not yet handshaken is lost.
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. If req_valid is high at a posedge, the request is accepted. All request fields are latched and the counter is loaded with LATENCY-1.
  - If LATENCY==1, the FSM goes directly to RESP and the access commits on this same edge.
  - Otherwise the FSM goes to WAIT.
- WAIT: req_ready=0. The counter decrements each cycle. When the counter equals 1, the next edge commits the access and enters RESP.
- Timing rule: a request accepted at edge T raises rsp_valid after edge T+LATENCY-1, so it is visible in the cycle following that edge. Equivalently, rsp_valid first samples high at edge T+LATENCY.
- Commit: the error check uses latched fields. rsp_err=1 when any of the following holds:
  - req_size==11
  - half access with addr[0]=1
  - word access with addr[1:0]!=00
  - word index >= DEPTH_WORDS
- Error commit: no storage write, rsp_rdata=0.
- Store commit (no error): writes only the addressed lanes.
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Half: lanes addr[1]*2 and addr[1]*2+1 get wdata[15:0].
  - Word: all lanes.
  - rsp_rdata=0.
- Load commit (no error): reads the addressed word and extracts the lane(s) indexed by addr[1:0]. The result is sign- or zero-extended to 32 bits according to req_unsigned. Word loads ignore req_unsigned.
- RESP: rsp_valid=1 and rsp_rdata/rsp_err are held stable until the response handshakes at an edge where rsp_ready=1. At that edge the FSM goes to IDLE and rsp_valid, rsp_rdata and rsp_err return to 0. req_ready=0 throughout RESP, so there is no overlap between requests; the next accept is possible at the edge after the return to IDLE.
- Request inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
- A load after a store to the same address returns the stored data, since commits are strictly ordered.

Test Plan:
- Word store then load, LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, size 10, accepted at edge T → rsp_valid high at edge T+2 with rsp_err=0 and rsp_rdata=0. Load addr 0x10 → rsp_rdata=0xDEADBEEF.
- Byte/half extension: after word 0x80FF7F01 at 0x20:
  - lb 0x23 → 0xFFFFFF80
  - lbu 0x23 → 0x00000080
  - lh 0x22 → 0xFFFF80FF
  - lhu 0x20 → 0x00007F01
- Partial store: sb 0x21 with wdata 0x000000AA over word 0x11223344 → lw 0x20 returns 0x1122AA44. sh 0x22 with wdata 0x0000BEEF → lw returns 0xBEEFAA44.
- Errors: each of the following gives rsp_err=1 and rsp_rdata=0, and a subsequent lw of the targeted word shows it unchanged:
  - lw 0x22
  - lh 0x21
  - size 11
  - sw to word index 1024
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stay stable and req_ready stays 0. Raise rsp_ready → rsp_valid drops after that edge and req_ready=1 the next cycle. Repeat with LATENCY=1 and LATENCY=4 to confirm latency exactly 1 and 4.
- Reset mid-operation: accept sw 0x30 with wdata 0x12345678 at LATENCY=4 and assert rst asynchronously before commit → outputs reset immediately (req_ready=1, rsp_valid=0). A following lw 0x30 returns the prior contents.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request and response channels,
// byte/half/word loads and stores with extension and alignment checking.
module dmem_responder #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   input  logic              rsp_ready
);

   localparam int IDX_W  = ADDR_W - 2;
   localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam bit FAST   = (LATENCY == 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state_q;
   logic [3:0]          cnt_q;
   logic                we_q;
   logic                uns_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [1:0]          size_q;
   logic                req_ready_q;
   logic                rsp_valid_q;
   logic                rsp_err_q;
   logic [DATA_W-1:0]   rsp_rdata_q;

   logic [DATA_W-1:0]   mem [DEPTH_WORDS];

   logic                c_we;
   logic                c_uns;
   logic [ADDR_W-1:0]   c_addr;
   logic [DATA_W-1:0]   c_wdata;
   logic [1:0]          c_size;
   logic [IDX_W-1:0]    c_idx;
   logic [MEM_AW-1:0]   widx;
   logic [1:0]          off;
   logic                commit;
   logic                rsp_err_d;
   logic [DATA_W-1:0]   rsp_rdata_d;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   wr_word;
   logic [DATA_W-1:0]   ld_val;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;

   // With LATENCY==1 the access commits on the accept edge, so it must use the live request.
   always_comb begin
      if (FAST) begin
         c_we    = req_we;
         c_uns   = req_unsigned;
         c_addr  = req_addr;
         c_wdata = req_wdata;
         c_size  = req_size;
      end else begin
         c_we    = we_q;
         c_uns   = uns_q;
         c_addr  = addr_q;
         c_wdata = wdata_q;
         c_size  = size_q;
      end
   end

   assign c_idx  = c_addr[ADDR_W-1:2];
   assign widx   = c_idx[MEM_AW-1:0];
   assign off    = c_addr[1:0];
   assign commit = !rst && (((state_q == IDLE) && req_valid && FAST) ||
                            ((state_q == WAIT) && (cnt_q == 4'd1)));

   always_comb begin
      rsp_err_d = (c_size == 2'b11) ||
                  ((c_size == 2'b01) && c_addr[0]) ||
                  ((c_size == 2'b10) && (off != 2'b00)) ||
                  (c_idx >= IDX_W'(DEPTH_WORDS));
   end

   assign rd_word = mem[widx];

   always_comb begin
      ld_byte = rd_word[{off, 3'b000} +: 8];
      ld_half = c_addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (c_size)
         2'b00:   ld_val = c_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   ld_val = c_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_val = rd_word;
      endcase
      rsp_rdata_d = (rsp_err_d || c_we) ? '0 : ld_val;
   end

   always_comb begin
      wr_word = rd_word;
      case (c_size)
         2'b00:   wr_word[{off, 3'b000} +: 8]        = c_wdata[7:0];
         2'b01:   wr_word[{c_addr[1], 4'b0000} +: 16] = c_wdata[15:0];
         default: wr_word                           = c_wdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (commit && c_we && !rsp_err_d) begin
         mem[widx] <= wr_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q        <= req_we;
                  uns_q       <= req_unsigned;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  size_q      <= req_size;
                  cnt_q       <= 4'(LATENCY - 1);
                  req_ready_q <= 1'b0;
                  if (FAST) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= rsp_rdata_d;
                     rsp_err_q   <= rsp_err_d;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= rsp_rdata_d;
                  rsp_err_q   <= rsp_err_d;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  req_ready_q <= 1'b1;
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
